tlul_slave_ram: RTL and testbench

TileLink-UL (TL-UL) slave endpoint that sits directly downstream of tlulMaster.
- Consumes A-channel requests (Get, PutFullData, PutPartialData).
- Services them from a small internal word-addressed register array.
- Returns AccessAck / AccessAckData on the D channel.
- Fully pipelined: one outstanding response register, one request per cycle when D is not back-pressured.

---
 rtl/tlul_pkg.sv | 46 ++++
 rtl/tlul_req_check.sv | 61 ++++++
 rtl/tlul_slave_ram.sv | 122 ++++++++++++
 tb/tb_tlul_slave_ram.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlul_pkg.sv
`default_nettype none
// ============================================================================
// tlul_pkg : TL-UL opcodes, default channel widths and A/D channel records
// Rev 1.0
// ============================================================================
package tlul_pkg;

  localparam logic [2:0] TL_A_PUTFULL       = 3'd0;
  localparam logic [2:0] TL_A_PUTPARTIAL    = 3'd1;
  localparam logic [2:0] TL_A_GET           = 3'd4;

  localparam logic [2:0] TL_D_ACCESSACK     = 3'd0;
  localparam logic [2:0] TL_D_ACCESSACKDATA = 3'd1;

  localparam int TL_DATA_WIDTH   = 32;
  localparam int TL_ADDR_WIDTH   = 32;
  localparam int TL_SOURCE_WIDTH = 4;
  localparam int TL_SIZE_WIDTH   = 2;

  typedef struct packed {
    logic [2:0]                 opcode;
    logic [2:0]                 param;
    logic [TL_SIZE_WIDTH-1:0]   size;
    logic [TL_SOURCE_WIDTH-1:0] source;
    logic [TL_ADDR_WIDTH-1:0]   address;
    logic [TL_DATA_WIDTH/8-1:0] mask;
    logic [TL_DATA_WIDTH-1:0]   data;
  } tl_a_req_t;

  typedef struct packed {
    logic [2:0]                 opcode;
    logic [1:0]                 param;
    logic [TL_SIZE_WIDTH-1:0]   size;
    logic [TL_SOURCE_WIDTH-1:0] source;
    logic                       sink;
    logic [TL_DATA_WIDTH-1:0]   data;
    logic                       error;
  } tl_d_rsp_t;

  // Index width that stays legal for a single-word array.
  function automatic int tl_clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tlul_req_check.sv
`default_nettype none
// ============================================================================
// tlul_req_check : combinational A-request legality check and word index
// Rev 1.0
// ============================================================================
module tlul_req_check
  import tlul_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    SIZE_WIDTH  = 2,
  parameter int                    DEPTH_WORDS = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
  input  logic [2:0]                              i_opcode,
  input  logic [SIZE_WIDTH-1:0]                   i_size,
  input  logic [ADDR_WIDTH-1:0]                   i_address,
  input  logic [DATA_WIDTH/8-1:0]                 i_mask,
  output logic                                    o_err,
  output logic [tl_clog2_min1(DEPTH_WORDS)-1:0]   o_index
);

  localparam int c_bytes = DATA_WIDTH / 8;
  localparam int c_off_w = $clog2(c_bytes);
  localparam int c_idx_w = tl_clog2_min1(DEPTH_WORDS);
  localparam logic [ADDR_WIDTH:0] c_span = (ADDR_WIDTH + 1)'(DEPTH_WORDS * c_bytes);

  logic [ADDR_WIDTH-1:0] w_offset;
  logic                  w_in_range;
  logic                  w_size_ok;
  logic                  w_aligned;
  logic                  w_op_ok;
  logic [c_bytes-1:0]    w_window;
  logic [31:0]           w_lo;
  logic [31:0]           w_nbytes;

  assign w_offset   = i_address - BASE_ADDR;
  assign w_in_range = (i_address >= BASE_ADDR) && ({1'b0, w_offset} < c_span);
  assign w_size_ok  = (int'(i_size) <= c_off_w);
  assign w_nbytes   = w_size_ok ? (32'd1 << i_size) : 32'd0;
  // BASE_ADDR is array aligned, so the offset's low bits are the byte lane.
  assign w_lo       = 32'(w_offset) & 32'(c_bytes - 1);
  assign w_aligned  = ((w_lo & (w_nbytes - 32'd1)) == 32'd0);
  assign w_op_ok    = (i_opcode == TL_A_PUTFULL) || (i_opcode == TL_A_PUTPARTIAL) ||
                      (i_opcode == TL_A_GET);

  always_comb begin
    w_window = '0;
    for (int unsigned i = 0; i < c_bytes; i++) begin
      w_window[i] = (i >= w_lo) && (i < w_lo + w_nbytes);
    end
  end

  assign o_err = !w_op_ok || !w_in_range || !w_size_ok || !w_aligned ||
                 (|(i_mask & ~w_window)) ||
                 ((i_opcode == TL_A_PUTFULL) && (i_mask != w_window));

  assign o_index = c_idx_w'(w_offset >> c_off_w);

endmodule
`default_nettype wire

// File: rtl/tlul_slave_ram.sv
`default_nettype none
// ============================================================================
// tlul_slave_ram : TL-UL slave backed by a small register array, 1-cycle D
// Rev 1.0
// ============================================================================
module tlul_slave_ram
  import tlul_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    SOURCE_WIDTH = 4,
  parameter int                    SIZE_WIDTH   = 2,
  parameter int                    DEPTH_WORDS  = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic                      i_a_valid,
  output logic                      o_a_ready,
  input  logic [2:0]                i_a_opcode,
  input  logic [2:0]                i_a_param,
  input  logic [SIZE_WIDTH-1:0]     i_a_size,
  input  logic [SOURCE_WIDTH-1:0]   i_a_source,
  input  logic [ADDR_WIDTH-1:0]     i_a_address,
  input  logic [DATA_WIDTH/8-1:0]   i_a_mask,
  input  logic [DATA_WIDTH-1:0]     i_a_data,
  output logic                      o_d_valid,
  input  logic                      i_d_ready,
  output logic [2:0]                o_d_opcode,
  output logic [1:0]                o_d_param,
  output logic [SIZE_WIDTH-1:0]     o_d_size,
  output logic [SOURCE_WIDTH-1:0]   o_d_source,
  output logic                      o_d_sink,
  output logic [DATA_WIDTH-1:0]     o_d_data,
  output logic                      o_d_error
);

  localparam int c_bytes = DATA_WIDTH / 8;
  localparam int c_idx_w = tl_clog2_min1(DEPTH_WORDS);

  logic [DATA_WIDTH-1:0]   r_mem [DEPTH_WORDS];
  logic                    r_d_valid;
  logic [2:0]              r_d_opcode;
  logic [SIZE_WIDTH-1:0]   r_d_size;
  logic [SOURCE_WIDTH-1:0] r_d_source;
  logic [DATA_WIDTH-1:0]   r_d_data;
  logic                    r_d_error;

  logic                    w_a_fire;
  logic                    w_is_put;
  logic                    w_write;
  logic                    w_err;
  logic [c_idx_w-1:0]      w_index;
  logic                    w_unused_param;

  tlul_req_check #(
    .DATA_WIDTH  (DATA_WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .SIZE_WIDTH  (SIZE_WIDTH),
    .DEPTH_WORDS (DEPTH_WORDS),
    .BASE_ADDR   (BASE_ADDR)
  ) u_req_check (
    .i_opcode  (i_a_opcode),
    .i_size    (i_a_size),
    .i_address (i_a_address),
    .i_mask    (i_a_mask),
    .o_err     (w_err),
    .o_index   (w_index)
  );

  // A is accepted whenever the single response slot is free or draining now.
  assign o_a_ready      = !r_d_valid || i_d_ready;
  assign w_a_fire       = i_a_valid && o_a_ready;
  assign w_is_put       = (i_a_opcode == TL_A_PUTFULL) || (i_a_opcode == TL_A_PUTPARTIAL);
  assign w_write        = w_a_fire && w_is_put && !w_err;
  assign w_unused_param = ^i_a_param;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_d_valid  <= 1'b0;
      r_d_opcode <= '0;
      r_d_size   <= '0;
      r_d_source <= '0;
      r_d_data   <= '0;
      r_d_error  <= 1'b0;
    end else if (w_a_fire) begin
      r_d_valid  <= 1'b1;
      r_d_opcode <= w_is_put ? TL_D_ACCESSACK : TL_D_ACCESSACKDATA;
      r_d_size   <= i_a_size;
      r_d_source <= i_a_source;
      r_d_data   <= (w_is_put || w_err) ? '0 : r_mem[w_index];
      r_d_error  <= w_err;
    end else if (i_d_ready) begin
      r_d_valid  <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int w = 0; w < DEPTH_WORDS; w++) begin
        r_mem[w] <= '0;
      end
    end else if (w_write) begin
      for (int b = 0; b < c_bytes; b++) begin
        if (i_a_mask[b]) begin
          r_mem[w_index][8*b +: 8] <= i_a_data[8*b +: 8];
        end
      end
    end
  end

  assign o_d_valid  = r_d_valid;
  assign o_d_opcode = r_d_opcode;
  assign o_d_param  = 2'b00;
  assign o_d_size   = r_d_size;
  assign o_d_source = r_d_source;
  assign o_d_sink   = 1'b0;
  assign o_d_data   = r_d_data;
  assign o_d_error  = r_d_error;

endmodule
`default_nettype wire

// File: tb/tb_tlul_slave_ram.sv
`default_nettype none
// ============================================================================
// tb_tlul_slave_ram : vector table, corner sequences and randomized traffic
// Rev 1.0
// ============================================================================
module tb_tlul_slave_ram;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_valid = 1'b0;
  logic        a_ready;
  logic [2:0]  a_opcode = '0;
  logic [2:0]  a_param = '0;
  logic [1:0]  a_size = '0;
  logic [3:0]  a_source = '0;
  logic [31:0] a_address = '0;
  logic [3:0]  a_mask = '0;
  logic [31:0] a_data = '0;
  logic        d_valid;
  logic        d_ready = 1'b1;
  logic [2:0]  d_opcode;
  logic [1:0]  d_param;
  logic [1:0]  d_size;
  logic [3:0]  d_source;
  logic        d_sink;
  logic [31:0] d_data;
  logic        d_error;

  int checks = 0;
  int errors = 0;

  tlul_slave_ram dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_a_valid   (a_valid),
    .o_a_ready   (a_ready),
    .i_a_opcode  (a_opcode),
    .i_a_param   (a_param),
    .i_a_size    (a_size),
    .i_a_source  (a_source),
    .i_a_address (a_address),
    .i_a_mask    (a_mask),
    .i_a_data    (a_data),
    .o_d_valid   (d_valid),
    .i_d_ready   (d_ready),
    .o_d_opcode  (d_opcode),
    .o_d_param   (d_param),
    .o_d_size    (d_size),
    .o_d_source  (d_source),
    .o_d_sink    (d_sink),
    .o_d_data    (d_data),
    .o_d_error   (d_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
    logic [3:0]  src;
    logic        e_err;
    logic [2:0]  e_op;
    logic [31:0] e_data;
  } vec_t;

  vec_t        vecs[18];
  logic [31:0] exp_mem[16];

  // Reference response state for the randomized phase.
  logic        m_dv;
  logic [2:0]  m_op;
  logic [1:0]  m_size;
  logic [3:0]  m_src;
  logic [31:0] m_data;
  logic        m_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [1:0] sz,
                       input logic [31:0] addr, input logic [3:0] mask,
                       input logic [31:0] data, input logic [3:0] src);
    a_valid   = v;
    a_opcode  = op;
    a_size    = sz;
    a_address = addr;
    a_mask    = mask;
    a_data    = data;
    a_source  = src;
    a_param   = 3'(src);
  endtask

  // Spec-level request semantics: legality rules, byte-lane writes, word reads.
  task automatic model_req(input logic [2:0] op, input logic [1:0] sz, input logic [31:0] addr,
                           input logic [3:0] mask, input logic [31:0] data,
                           output logic err, output logic [2:0] dop, output logic [31:0] dd);
    int   nbytes, lo, widx;
    logic [3:0] win;
    logic is_put;
    is_put = (op == 3'd0) || (op == 3'd1);
    err    = !(is_put || op == 3'd4);
    if (addr >= 32'd64) err = 1'b1;
    if (sz > 2'd2) err = 1'b1;
    nbytes = 1 << sz;
    if ((addr % nbytes) != 0) err = 1'b1;
    lo  = int'(addr % 4);
    win = '0;
    for (int b = 0; b < 4; b++) if (b >= lo && b < lo + nbytes) win[b] = 1'b1;
    if ((mask & ~win) != 4'd0) err = 1'b1;
    if (op == 3'd0 && mask != win) err = 1'b1;
    dop  = is_put ? 3'd0 : 3'd1;
    dd   = '0;
    widx = int'((addr / 4) % 16);
    if (!err) begin
      if (is_put) begin
        for (int b = 0; b < 4; b++) if (mask[b]) exp_mem[widx][8*b +: 8] = data[8*b +: 8];
      end else begin
        dd = exp_mem[widx];
      end
    end
  endtask

  logic [2:0]  r_op;
  logic [1:0]  r_sz;
  logic [31:0] r_addr;
  logic [3:0]  r_mask;
  logic [31:0] r_dat;
  logic [3:0]  r_src;
  logic        r_v;
  logic        r_dr;
  logic        e_ready;
  logic        t_err;
  logic [2:0]  t_op;
  logic [31:0] t_data;

  initial begin
    //          op    sz    addr       mask  data          src  err   op    data
    vecs[0]  = '{3'd0, 2'd2, 32'h08, 4'hF, 32'hDEADBEEF, 4'd3, 1'b0, 3'd0, 32'h0};
    vecs[1]  = '{3'd4, 2'd2, 32'h08, 4'hF, 32'h0,        4'd1, 1'b0, 3'd1, 32'hDEADBEEF};
    vecs[2]  = '{3'd1, 2'd2, 32'h08, 4'h2, 32'h0000AA00, 4'd2, 1'b0, 3'd0, 32'h0};
    vecs[3]  = '{3'd4, 2'd2, 32'h08, 4'hF, 32'h0,        4'd4, 1'b0, 3'd1, 32'hDEADAAEF};
    vecs[4]  = '{3'd4, 2'd2, 32'h40, 4'hF, 32'h0,        4'd5, 1'b1, 3'd1, 32'h0};
    vecs[5]  = '{3'd4, 2'd2, 32'h06, 4'hF, 32'h0,        4'd6, 1'b1, 3'd1, 32'h0};
    vecs[6]  = '{3'd2, 2'd2, 32'h08, 4'hF, 32'h0,        4'd7, 1'b1, 3'd1, 32'h0};
    vecs[7]  = '{3'd4, 2'd2, 32'h08, 4'hF, 32'h0,        4'd8, 1'b0, 3'd1, 32'hDEADAAEF};
    vecs[8]  = '{3'd0, 2'd2, 32'h3C, 4'hF, 32'h12345678, 4'd5, 1'b0, 3'd0, 32'h0};
    vecs[9]  = '{3'd4, 2'd2, 32'h3C, 4'hF, 32'h0,        4'd9, 1'b0, 3'd1, 32'h12345678};
    vecs[10] = '{3'd4, 2'd3, 32'h00, 4'hF, 32'h0,        4'd1, 1'b1, 3'd1, 32'h0};
    vecs[11] = '{3'd1, 2'd1, 32'h00, 4'h4, 32'hFFFFFFFF, 4'd2, 1'b1, 3'd0, 32'h0};
    vecs[12] = '{3'd0, 2'd2, 32'h00, 4'h7, 32'hFFFFFFFF, 4'd3, 1'b1, 3'd0, 32'h0};
    vecs[13] = '{3'd1, 2'd0, 32'h01, 4'h2, 32'h00005500, 4'd4, 1'b0, 3'd0, 32'h0};
    vecs[14] = '{3'd4, 2'd2, 32'h00, 4'hF, 32'h0,        4'd5, 1'b0, 3'd1, 32'h00005500};
    vecs[15] = '{3'd0, 2'd2, 32'h40, 4'hF, 32'hCAFEF00D, 4'd6, 1'b1, 3'd0, 32'h0};
    vecs[16] = '{3'd4, 2'd2, 32'h00, 4'hF, 32'h0,        4'd7, 1'b0, 3'd1, 32'h00005500};
    vecs[17] = '{3'd5, 2'd2, 32'h00, 4'hF, 32'h0,        4'd8, 1'b1, 3'd1, 32'h0};

    // Reset state
    #2;
    chk("rst_d_valid", 64'(d_valid), 64'd0);
    chk("rst_a_ready", 64'(a_ready), 64'd1);
    chk("rst_d_opcode", 64'(d_opcode), 64'd0);
    chk("rst_d_data", 64'(d_data), 64'd0);
    chk("rst_d_error", 64'(d_error), 64'd0);
    chk("rst_d_source", 64'(d_source), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Vector table, issued back to back
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].op, vecs[i].size, vecs[i].addr, vecs[i].mask, vecs[i].data, vecs[i].src);
      #1;
      chk($sformatf("vec%0d_a_ready", i), 64'(a_ready), 64'd1);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_d_valid", i), 64'(d_valid), 64'd1);
      chk($sformatf("vec%0d_d_opcode", i), 64'(d_opcode), 64'(vecs[i].e_op));
      chk($sformatf("vec%0d_d_error", i), 64'(d_error), 64'(vecs[i].e_err));
      chk($sformatf("vec%0d_d_data", i), 64'(d_data), 64'(vecs[i].e_data));
      chk($sformatf("vec%0d_d_source", i), 64'(d_source), 64'(vecs[i].src));
      chk($sformatf("vec%0d_d_size", i), 64'(d_size), 64'(vecs[i].size));
      chk($sformatf("vec%0d_param_sink", i), 64'({d_param, d_sink}), 64'd0);
    end
    drive(1'b0, 3'd4, 2'd2, 32'h0, 4'hF, 32'h0, 4'd0);
    @(posedge clk); #1;
    chk("idle_d_valid", 64'(d_valid), 64'd0);

    // Back-to-back Gets at full throughput
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 3'd4, 2'd2, 32'(4 * k), 4'hF, 32'h0, 4'(10 + k));
      #1;
      chk($sformatf("b2b%0d_a_ready", k), 64'(a_ready), 64'd1);
      @(posedge clk); #1;
      chk($sformatf("b2b%0d_d_valid", k), 64'(d_valid), 64'd1);
      chk($sformatf("b2b%0d_d_source", k), 64'(d_source), 64'(10 + k));
      chk($sformatf("b2b%0d_d_data", k), 64'(d_data),
          (k == 0) ? 64'h00005500 : (k == 1) ? 64'h0 : 64'hDEADAAEF);
    end

    // D back-pressure for 5 cycles with a waiting request
    drive(1'b1, 3'd4, 2'd2, 32'h08, 4'hF, 32'h0, 4'd9);
    @(posedge clk); #1;
    d_ready = 1'b0;
    drive(1'b1, 3'd4, 2'd2, 32'h3C, 4'hF, 32'h0, 4'd4);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("stall%0d_a_ready", k), 64'(a_ready), 64'd0);
      @(posedge clk); #1;
      chk($sformatf("stall%0d_d_valid", k), 64'(d_valid), 64'd1);
      chk($sformatf("stall%0d_d_source", k), 64'(d_source), 64'd9);
      chk($sformatf("stall%0d_d_data", k), 64'(d_data), 64'hDEADAAEF);
      chk($sformatf("stall%0d_d_opcode", k), 64'(d_opcode), 64'd1);
    end
    d_ready = 1'b1;
    #1;
    chk("unstall_a_ready", 64'(a_ready), 64'd1);
    @(posedge clk); #1;
    chk("unstall_d_valid", 64'(d_valid), 64'd1);
    chk("unstall_d_source", 64'(d_source), 64'd4);
    chk("unstall_d_data", 64'(d_data), 64'h12345678);
    drive(1'b0, 3'd4, 2'd2, 32'h0, 4'hF, 32'h0, 4'd0);
    @(posedge clk); #1;
    chk("unstall_drain", 64'(d_valid), 64'd0);

    // Asynchronous reset while a response is pending
    drive(1'b1, 3'd4, 2'd2, 32'h08, 4'hF, 32'h0, 4'd1);
    @(posedge clk); #1;
    drive(1'b0, 3'd4, 2'd2, 32'h0, 4'hF, 32'h0, 4'd0);
    d_ready = 1'b0;
    chk("pre_rst_d_valid", 64'(d_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_d_valid", 64'(d_valid), 64'd0);
    chk("async_rst_a_ready", 64'(a_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    d_ready = 1'b1;
    @(posedge clk); #1;
    drive(1'b1, 3'd4, 2'd2, 32'h08, 4'hF, 32'h0, 4'd2);
    @(posedge clk); #1;
    chk("post_rst_d_valid", 64'(d_valid), 64'd1);
    chk("post_rst_d_data", 64'(d_data), 64'h0);
    chk("post_rst_d_error", 64'(d_error), 64'd0);
    drive(1'b0, 3'd4, 2'd2, 32'h0, 4'hF, 32'h0, 4'd0);
    @(posedge clk); #1;

    // Randomized traffic against the reference model
    foreach (exp_mem[i]) exp_mem[i] = '0;
    m_dv = 1'b0; m_op = '0; m_size = '0; m_src = '0; m_data = '0; m_err = 1'b0;
    for (int n = 0; n < 600; n++) begin
      int sel, lo, word;
      sel  = int'($urandom_range(0, 9));
      r_op = (sel < 3) ? 3'd0 : (sel < 6) ? 3'd1 : (sel < 9) ? 3'd4 : 3'($urandom_range(0, 7));
      r_sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      lo   = (r_sz <= 2'd2) ? ((int'($urandom_range(0, 3)) >> r_sz) << r_sz) : 0;
      word = int'($urandom_range(0, 17));
      r_addr = 32'(word * 4 + lo);
      if ($urandom_range(0, 9) == 0) r_addr = r_addr + 32'd1;
      r_mask = '0;
      for (int b = 0; b < 4; b++) if (b >= lo && b < lo + (1 << r_sz)) r_mask[b] = 1'b1;
      if ($urandom_range(0, 3) == 0) r_mask = 4'($urandom_range(0, 15));
      r_dat = $urandom;
      r_src = 4'($urandom_range(0, 15));
      r_v   = ($urandom_range(0, 3) != 0);
      r_dr  = ($urandom_range(0, 3) != 0);
      drive(r_v, r_op, r_sz, r_addr, r_mask, r_dat, r_src);
      d_ready = r_dr;
      #1;
      e_ready = !m_dv || r_dr;
      chk("rnd_a_ready", 64'(a_ready), 64'(e_ready));
      if (r_v && e_ready) begin
        model_req(r_op, r_sz, r_addr, r_mask, r_dat, t_err, t_op, t_data);
        m_dv = 1'b1; m_op = t_op; m_size = r_sz; m_src = r_src; m_data = t_data; m_err = t_err;
      end else if (m_dv && r_dr) begin
        m_dv = 1'b0;
      end
      @(posedge clk); #1;
      chk("rnd_d_valid", 64'(d_valid), 64'(m_dv));
      if (m_dv) begin
        chk("rnd_d_opcode", 64'(d_opcode), 64'(m_op));
        chk("rnd_d_error", 64'(d_error), 64'(m_err));
        chk("rnd_d_data", 64'(d_data), 64'(m_data));
        chk("rnd_d_source", 64'(d_source), 64'(m_src));
        chk("rnd_d_size", 64'(d_size), 64'(m_size));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
